vga_sync_gen: RTL and testbench

Raster timing generator: the source end of the `pixel_x` / `pixel_y` / `video_on` interface consumed by the pixel-generator blocks (ball, walls, overlays). It does the following:

- Divides the system clock into a pixel-rate enable.
- Runs horizontal and vertical scan counters.
- Drives `hsync`, `vsync`, `video_on` and the scan coordinates, all cycle-aligned, plus a one-clock frame-start strobe.

Default parameters give 640x480 @ 60 Hz from a 100 MHz `clk`.

---
 rtl/vga_sync_gen.sv | 90 +++++++++
 tb/tb_vga_sync_gen.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel-rate enable, horizontal/vertical scan counters and
// registered sync/blanking decodes that stay cycle-aligned with the scan coordinates.
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int SYNC_POL  = 0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        pixel_tick,
    output logic [11:0] pixel_x,
    output logic [11:0] pixel_y,
    output logic        video_on,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [11:0] X_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] Y_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] X_VIS    = 12'(H_DISPLAY);
    localparam logic [11:0] Y_VIS    = 12'(V_DISPLAY);
    localparam logic [11:0] HS_START = 12'(H_DISPLAY + H_FRONT);
    localparam logic [11:0] HS_STOP  = 12'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [11:0] VS_START = 12'(V_DISPLAY + V_FRONT);
    localparam logic [11:0] VS_STOP  = 12'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic        SYNC_ACT = (SYNC_POL != 0);

    logic [DIV_W-1:0] div;
    logic [11:0]      x_next;
    logic [11:0]      y_next;

    function automatic logic visible(input logic [11:0] x, input logic [11:0] y);
        return (x < X_VIS) && (y < Y_VIS);
    endfunction

    function automatic logic sync_level(input logic [11:0] pos, input logic [11:0] start,
                                        input logic [11:0] stop);
        return ((pos >= start) && (pos < stop)) ? SYNC_ACT : ~SYNC_ACT;
    endfunction

    // With CLK_DIV = 1 the divider is a constant zero, so the tick is permanently high.
    assign pixel_tick = (div == DIV_LAST);

    always_comb begin
        x_next = pixel_x + 12'd1;
        y_next = pixel_y;
        if (pixel_x == X_LAST) begin
            x_next = '0;
            y_next = (pixel_y == Y_LAST) ? 12'd0 : pixel_y + 12'd1;
        end
    end

    // Decodes are taken from the next-state position so they land on the same edge as it.
    always_ff @(posedge clk) begin
        if (rst) begin
            div         <= '0;
            pixel_x     <= X_LAST;
            pixel_y     <= Y_LAST;
            video_on    <= 1'b0;
            hsync       <= ~SYNC_ACT;
            vsync       <= ~SYNC_ACT;
            frame_start <= 1'b0;
        end else begin
            div         <= pixel_tick ? '0 : div + 1'b1;
            frame_start <= 1'b0;
            if (pixel_tick) begin
                pixel_x     <= x_next;
                pixel_y     <= y_next;
                video_on    <= visible(x_next, y_next);
                hsync       <= sync_level(x_next, HS_START, HS_STOP);
                vsync       <= sync_level(y_next, VS_START, VS_STOP);
                frame_start <= (x_next == 12'd0) && (y_next == 12'd0);
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three parameterisations checked against an arithmetic raster
// model driven by the number of non-reset clock edges since the last reset.
module tb_vga_sync_gen;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        von;
        logic        hs;
        logic        vs;
        logic        fs;
        logic        tick;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    logic tick_a, von_a, hs_a, vs_a, fs_a;
    logic tick_b, von_b, hs_b, vs_b, fs_b;
    logic tick_c, von_c, hs_c, vs_c, fs_c;
    logic [11:0] x_a, y_a, x_b, y_b, x_c, y_c;

    int checks = 0;
    int errors = 0;

    // Default 640x480, CLK_DIV 4, active-low syncs.
    vga_sync_gen dut_a (
        .clk(clk), .rst(rst_a), .pixel_tick(tick_a), .pixel_x(x_a), .pixel_y(y_a),
        .video_on(von_a), .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a)
    );

    // Miniature raster so full frames are cheap: 25 x 17, CLK_DIV 3.
    vga_sync_gen #(
        .CLK_DIV(3), .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
        .V_DISPLAY(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_POL(0)
    ) dut_b (
        .clk(clk), .rst(rst_b), .pixel_tick(tick_b), .pixel_x(x_b), .pixel_y(y_b),
        .video_on(von_b), .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b)
    );

    // Default raster at one clock per pixel with active-high syncs.
    vga_sync_gen #(.CLK_DIV(1), .SYNC_POL(1)) dut_c (
        .clk(clk), .rst(rst_c), .pixel_tick(tick_c), .pixel_x(x_c), .pixel_y(y_c),
        .video_on(von_c), .hsync(hs_c), .vsync(vs_c), .frame_start(fs_c)
    );

    obs_t obs_a, obs_b, obs_c;
    assign obs_a = {x_a, y_a, von_a, hs_a, vs_a, fs_a, tick_a};
    assign obs_b = {x_b, y_b, von_b, hs_b, vs_b, fs_b, tick_b};
    assign obs_c = {x_c, y_c, von_c, hs_c, vs_c, fs_c, tick_c};

    // Edges seen with reset low since the last reset edge.
    longint k_a = 0, k_b = 0, k_c = 0;
    always @(posedge clk) begin
        k_a <= rst_a ? 64'sd0 : k_a + 1;
        k_b <= rst_b ? 64'sd0 : k_b + 1;
        k_c <= rst_c ? 64'sd0 : k_c + 1;
    end

    // After k edges the position has advanced floor(k/cdiv) times from the parked corner.
    function automatic obs_t model(input int cdiv, input int hd, input int hf, input int hsw,
                                   input int hb, input int vd, input int vf, input int vsw,
                                   input int vb, input bit pol, input longint k);
        int ht = hd + hf + hsw + hb;
        int vt = vd + vf + vsw + vb;
        longint t = k / cdiv;
        longint idx = -1;
        int x, y;
        obs_t e;
        if (t == 0) begin
            x = ht - 1;
            y = vt - 1;
        end else begin
            idx = (t - 1) % (ht * vt);
            x = int'(idx % ht);
            y = int'(idx / ht);
        end
        e.x    = 12'(x);
        e.y    = 12'(y);
        e.von  = (x < hd) && (y < vd);
        e.hs   = (x >= hd + hf && x < hd + hf + hsw) ? pol : ~pol;
        e.vs   = (y >= vd + vf && y < vd + vf + vsw) ? pol : ~pol;
        e.fs   = (idx == 0) && (k % cdiv == 0);
        e.tick = (k % cdiv) == cdiv - 1;
        return e;
    endfunction

    function automatic obs_t model_a(input longint k);
        return model(4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, k);
    endfunction
    function automatic obs_t model_b(input longint k);
        return model(3, 16, 2, 3, 4, 10, 2, 2, 3, 1'b0, k);
    endfunction
    function automatic obs_t model_c(input longint k);
        return model(1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1, k);
    endfunction

    task automatic test_reset();
        obs_t want;
        rst_a = 1'b1;
        repeat (3) @(negedge clk);
        want = {12'd799, 12'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs_a !== want) begin
            errors++;
            $display("FAIL reset_values got %h want %h", obs_a, want);
        end
        rst_a = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++;
            if (i < 4 && (x_a !== 12'd799 || fs_a !== 1'b0)) begin
                errors++;
                $display("FAIL reset_hold edge %0d got x=%0d fs=%b want x=799 fs=0", i, x_a, fs_a);
            end else if (i == 4 && obs_a !== {12'd0, 12'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL first_pixel got %h want x=0 y=0 von=1 fs=1", obs_a);
            end
        end
        @(negedge clk);
        checks++;
        if (fs_a !== 1'b0 || x_a !== 12'd0) begin
            errors++;
            $display("FAIL fs_width got fs=%b x=%0d want fs=0 x=0", fs_a, x_a);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (x_a !== 12'd1 || fs_a !== 1'b0) begin
            errors++;
            $display("FAIL second_pixel got x=%0d fs=%b want x=1 fs=0", x_a, fs_a);
        end
    endtask

    task automatic test_line();
        int von_ticks = 0;
        int hs_low = 0;
        longint start1 = -1, start2 = -1;
        logic [11:0] prev_x = x_a;
        for (int i = 0; i < 6500; i++) begin
            @(negedge clk);
            checks++;
            if (obs_a !== model_a(k_a)) begin
                errors++;
                $display("FAIL line_cycle k=%0d got %h want %h", k_a, obs_a, model_a(k_a));
            end
            if (y_a == 12'd1 && von_a && tick_a) von_ticks++;
            if (y_a == 12'd1 && !hs_a) hs_low++;
            if (x_a == 12'd0 && prev_x != 12'd0) begin
                if (y_a == 12'd1) start1 = k_a;
                if (y_a == 12'd2) start2 = k_a;
            end
            prev_x = x_a;
        end
        checks++;
        if (von_ticks != 640) begin
            errors++;
            $display("FAIL line_video_ticks got %0d want 640", von_ticks);
        end
        checks++;
        if (hs_low != 384) begin
            errors++;
            $display("FAIL line_hsync_clks got %0d want 384", hs_low);
        end
        checks++;
        if (start1 < 0 || start2 - start1 != 3200) begin
            errors++;
            $display("FAIL line_period got %0d want 3200", start2 - start1);
        end
    endtask

    task automatic test_random_reset();
        for (int it = 0; it < 5; it++) begin
            int run = $urandom_range(2500, 20);
            int hold = $urandom_range(4, 1);
            for (int i = 0; i < run; i++) begin
                @(negedge clk);
                checks++;
                if (obs_a !== model_a(k_a)) begin
                    errors++;
                    $display("FAIL rand_run it=%0d k=%0d got %h want %h", it, k_a, obs_a, model_a(k_a));
                end
            end
            rst_a = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                checks++;
                if (obs_a !== model_a(k_a)) begin
                    errors++;
                    $display("FAIL rand_reset it=%0d got %h want %h", it, obs_a, model_a(k_a));
                end
            end
            rst_a = 1'b0;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (obs_a !== model_a(k_a)) begin
                errors++;
                $display("FAIL rand_tail k=%0d got %h want %h", k_a, obs_a, model_a(k_a));
            end
        end
    endtask

    task automatic test_mid_reset();
        bit found = 0;
        rst_b = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (x_b == 12'd10 && y_b == 12'd5 && (k_b % 3) == 2) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_reset_reach got x=%0d y=%0d want x=10 y=5 div=2", x_b, y_b);
        end
        rst_b = 1'b1;
        @(negedge clk);
        checks++;
        if (obs_b !== {12'd24, 12'd16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_values got %h want x=24 y=16 parked", obs_b);
        end
        rst_b = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++;
            if (obs_b !== model_b(k_b)) begin
                errors++;
                $display("FAIL mid_reset_restart edge %0d got %h want %h", i, obs_b, model_b(k_b));
            end
        end
    endtask

    task automatic test_frame();
        int nfs = 0;
        int vs_ticks = 0;
        longint last_fs = 0;
        for (int i = 0; i < 4000 && nfs < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs_b !== model_b(k_b)) begin
                errors++;
                $display("FAIL frame_cycle k=%0d got %h want %h", k_b, obs_b, model_b(k_b));
            end
            checks++;
            if ({von_b, hs_b, vs_b} !== {(x_b < 16 && y_b < 10), !(x_b >= 18 && x_b < 21),
                                         !(y_b >= 12 && y_b < 14)}) begin
                errors++;
                $display("FAIL align x=%0d y=%0d got von/hs/vs=%b%b%b", x_b, y_b, von_b, hs_b, vs_b);
            end
            if (nfs == 1 && !vs_b && tick_b) vs_ticks++;
            if (fs_b) begin
                if (nfs >= 1) begin
                    checks++;
                    if (k_b - last_fs != 1275) begin
                        errors++;
                        $display("FAIL frame_period got %0d want 1275", k_b - last_fs);
                    end
                end
                last_fs = k_b;
                nfs++;
            end
        end
        checks++;
        if (nfs < 3) begin
            errors++;
            $display("FAIL frame_timeout got %0d frame starts want 3", nfs);
        end
        checks++;
        if (vs_ticks != 50) begin
            errors++;
            $display("FAIL frame_vsync_ticks got %0d want 50", vs_ticks);
        end
    endtask

    task automatic test_clkdiv1();
        int hs_high = 0;
        int still = 0;
        logic [11:0] prev_x;
        @(negedge clk);
        checks++;
        if (tick_c !== 1'b1 || x_c !== 12'd799 || hs_c !== 1'b0 || vs_c !== 1'b0) begin
            errors++;
            $display("FAIL div1_reset got tick=%b x=%0d hs=%b vs=%b want 1 799 0 0", tick_c, x_c, hs_c, vs_c);
        end
        rst_c = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_c !== {12'd0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL div1_first got %h want x=0 y=0 von=1 fs=1 tick=1", obs_c);
        end
        prev_x = x_c;
        for (int i = 0; i < 1700; i++) begin
            @(negedge clk);
            checks++;
            if (obs_c !== model_c(k_c)) begin
                errors++;
                $display("FAIL div1_cycle k=%0d got %h want %h", k_c, obs_c, model_c(k_c));
            end
            if (y_c == 12'd1 && hs_c) hs_high++;
            if (x_c == prev_x) still++;
            prev_x = x_c;
        end
        checks++;
        if (hs_high != 96) begin
            errors++;
            $display("FAIL div1_hsync_clks got %0d want 96", hs_high);
        end
        checks++;
        if (still != 0) begin
            errors++;
            $display("FAIL div1_x_static got %0d cycles want 0", still);
        end
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;
        test_reset();
        test_line();
        test_random_reset();
        test_mid_reset();
        test_frame();
        test_clkdiv1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
